// File: rtl/lvmon_adc_ctrl.sv
// rtl/lvmon_adc_ctrl.sv - serial frame controller for the seven LV-monitor ADCs
// One START yields select, control byte out, 12-bit result in, DONE strobe.
module lvmon_adc_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        START,
  input  logic [2:0]  CHIP,
  input  logic [2:0]  CHAN,
  input  logic [1:0]  RNGBIP,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [11:0] DATA,
  output logic        LVADCCLK,
  output logic        LVADCDATA,
  output logic [6:0]  LVADCEN_B,
  input  logic        LVADCBACK
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_END  = CW'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_SHIFT, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     per_q, per_d;
  logic [7:0]     ctrl_q, ctrl_d;
  logic [11:0]    sh_q, sh_d;
  logic [11:0]    data_q, data_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           sclk_q, sclk_d;
  logic           sdo_q, sdo_d;
  logic [6:0]     en_b_q, en_b_d;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      ctrl_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      en_b_q  <= 7'h7F;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ctrl_q  <= ctrl_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      en_b_q  <= en_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    ctrl_d  = ctrl_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    en_b_d  = en_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (CHIP == 3'd7) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SEL;
            cnt_d   = '0;
            ctrl_d  = {1'b1, CHAN, RNGBIP, 2'b01};
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
            en_b_d  = ~(7'd1 << CHIP);
          end
        end
      end
      S_SEL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          per_d   = '0;
          sdo_d   = ctrl_q[7];
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_END) sclk_d = 1'b1;
        // Falling edge: advance the control byte and capture read periods r=2..13.
        if (cnt_q == PER_END) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          ctrl_d = {ctrl_q[6:0], 1'b0};
          sdo_d  = ctrl_q[6];
          if (per_q >= 5'd9 && per_q <= 5'd20) sh_d = {sh_q[10:0], LVADCBACK};
          if (per_q == 5'd23) begin
            state_d = S_HOLD;
            per_d   = '0;
          end else begin
            per_d = per_q + 5'd1;
          end
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          en_b_d  = 7'h7F;
          done_d  = 1'b1;
          data_d  = sh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign DATA      = data_q;
  assign LVADCCLK  = sclk_q;
  assign LVADCDATA = sdo_q;
  assign LVADCEN_B = en_b_q;

endmodule

// File: tb/tb_lvmon_adc_ctrl.sv
// tb/tb_lvmon_adc_ctrl.sv - self-checking bench for lvmon_adc_ctrl
module tb_lvmon_adc_ctrl;

  localparam int D = 4;

  logic        CLK, RST_B, START, LVADCBACK;
  logic [2:0]  CHIP, CHAN;
  logic [1:0]  RNGBIP;
  logic        BUSY, DONE, ERR, LVADCCLK, LVADCDATA;
  logic [11:0] DATA;
  logic [6:0]  LVADCEN_B;

  int checks = 0;
  int errors = 0;

  lvmon_adc_ctrl #(.CLK_DIV(D)) dut (
    .CLK(CLK), .RST_B(RST_B), .START(START), .CHIP(CHIP), .CHAN(CHAN),
    .RNGBIP(RNGBIP), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DATA(DATA),
    .LVADCCLK(LVADCCLK), .LVADCDATA(LVADCDATA), .LVADCEN_B(LVADCEN_B),
    .LVADCBACK(LVADCBACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  chip;
    logic [2:0]  chan;
    logic [1:0]  rng;
    logic [11:0] val;
    logic [6:0]  exp_en;
    logic [7:0]  exp_ctrl;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC behaviour: result MSB first in r=2..13, deliberately wrong bits elsewhere.
  function automatic logic adc_bit(input logic [11:0] val, input int r);
    if (r >= 2 && r <= 13) return val[13 - r];
    if (r == 1) return ~val[11];
    if (r >= 14) return ~val[0];
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_ctrl(input logic [2:0] chan, input logic [1:0] rng);
    return 8'h80 + 8'(chan) * 8'd16 + 8'(rng) * 8'd4 + 8'd1;
  endfunction

  function automatic logic [6:0] model_en(input logic [2:0] chip);
    return 7'(127 - (1 << chip));
  endfunction

  task automatic issue_start(input logic [2:0] chip, input logic [2:0] chan, input logic [1:0] rng);
    CHIP = chip; CHAN = chan; RNGBIP = rng; START = 1'b1;
  endtask

  // Called #1 after the edge preceding the accepting edge, with START already high.
  task automatic run_frame(input string tag, input logic [11:0] val, input logic [6:0] exp_en,
                           input logic [7:0] exp_ctrl, input int inject_at, input bit chain,
                           input logic [2:0] nchip, input logic [2:0] nchan, input logic [1:0] nrng);
    int rises, first_rise, done_n, cs_bad;
    logic prev_clk;
    logic [7:0] byte_cap;
    rises = 0; first_rise = -1; done_n = -1; cs_bad = 0; prev_clk = 1'b0; byte_cap = '0;
    for (int n = 0; n < 60 * D && done_n < 0; n++) begin
      @(posedge CLK); #1;
      START = (n == inject_at);
      if (n == inject_at) CHIP = 3'($urandom_range(0, 7));
      if (LVADCCLK && !prev_clk) begin
        rises++;
        if (first_rise < 0) first_rise = n;
        if (rises <= 8) byte_cap = {byte_cap[6:0], LVADCDATA};
        LVADCBACK = adc_bit(val, rises - 8);
      end
      prev_clk = LVADCCLK;
      if (DONE) done_n = n;
      else if (BUSY !== 1'b1 || LVADCEN_B !== exp_en) cs_bad++;
    end
    chk({tag, " done_latency"}, 32'(done_n), 32'(50 * D));
    chk({tag, " data"}, 32'(DATA), 32'(val));
    chk({tag, " pulses"}, 32'(rises), 32'd24);
    chk({tag, " first_rise"}, 32'(first_rise), 32'(2 * D));
    chk({tag, " ctrl_byte"}, 32'(byte_cap), 32'(exp_ctrl));
    chk({tag, " cs_busy"}, 32'(cs_bad), 32'd0);
    chk({tag, " end_state"}, {24'd0, BUSY, LVADCEN_B}, {24'd0, 1'b0, 7'h7F});
    if (chain) begin
      issue_start(nchip, nchan, nrng);
    end else begin
      cs_bad = 0;
      for (int n = 0; n < 3 * D; n++) begin
        @(posedge CLK); #1;
        if (DONE || BUSY || LVADCEN_B !== 7'h7F) cs_bad++;
      end
      chk({tag, " quiet_after"}, 32'(cs_bad), 32'd0);
    end
  endtask

  initial begin
    int bad;
    logic [11:0] last;
    logic [2:0] rc, rch;
    logic [1:0] rr;
    logic [11:0] rv;

    vecs[0] = '{3'd0, 3'd5, 2'b10, 12'hA5C, 7'b1111110, 8'hD9};
    vecs[1] = '{3'd6, 3'd0, 2'b00, 12'hFFF, 7'b0111111, 8'h81};
    vecs[2] = '{3'd6, 3'd0, 2'b00, 12'h000, 7'b0111111, 8'h81};
    vecs[3] = '{3'd3, 3'd7, 2'b11, 12'h123, 7'b1110111, 8'hFD};
    vecs[4] = '{3'd1, 3'd2, 2'b01, 12'h800, 7'b1111101, 8'hA5};

    RST_B = 1'b0; START = 1'b0; CHIP = '0; CHAN = '0; RNGBIP = '0; LVADCBACK = 1'b0;

    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      START = ~START; CHIP = 3'(i);
      if (BUSY || DONE || ERR || LVADCCLK || LVADCDATA || DATA != 0 || LVADCEN_B !== 7'h7F) bad++;
    end
    chk("reset_hold", 32'(bad), 32'd0);
    chk("reset_en", 32'(LVADCEN_B), 32'h7F);
    chk("reset_data", 32'(DATA), 32'd0);
    START = 1'b0;
    RST_B = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (BUSY || DONE || ERR || LVADCCLK || LVADCDATA || DATA != 0 || LVADCEN_B !== 7'h7F) bad++;
    end
    chk("after_release", 32'(bad), 32'd0);

    for (int i = 0; i < 5; i++) begin
      issue_start(vecs[i].chip, vecs[i].chan, vecs[i].rng);
      run_frame($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp_en, vecs[i].exp_ctrl, -1, 1'b0, 0, 0, 0);
    end

    for (int i = 0; i < 6; i++) begin
      rc = 3'($urandom_range(0, 6)); rch = 3'($urandom); rr = 2'($urandom); rv = 12'($urandom);
      issue_start(rc, rch, rr);
      run_frame($sformatf("rand%0d", i), rv, model_en(rc), model_ctrl(rch, rr), -1, 1'b0, 0, 0, 0);
    end

    issue_start(vecs[3].chip, vecs[3].chan, vecs[3].rng);
    run_frame("ignore_start", vecs[3].val, vecs[3].exp_en, vecs[3].exp_ctrl, 50, 1'b0, 0, 0, 0);

    issue_start(vecs[0].chip, vecs[0].chan, vecs[0].rng);
    run_frame("chain_a", vecs[0].val, vecs[0].exp_en, vecs[0].exp_ctrl, -1, 1'b1,
              vecs[4].chip, vecs[4].chan, vecs[4].rng);
    run_frame("chain_b", vecs[4].val, vecs[4].exp_en, vecs[4].exp_ctrl, -1, 1'b0, 0, 0, 0);

    last = DATA;
    issue_start(3'd7, 3'd1, 2'b01);
    @(posedge CLK); #1;
    START = 1'b0;
    chk("err_pulse", {29'd0, ERR, BUSY, LVADCCLK}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("err_en", 32'(LVADCEN_B), 32'h7F);
    @(posedge CLK); #1;
    chk("err_one_cycle", 32'(ERR), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (ERR || BUSY || DONE || LVADCCLK || LVADCEN_B !== 7'h7F) bad++;
    end
    chk("err_quiet", 32'(bad), 32'd0);
    chk("err_data_kept", 32'(DATA), 32'(last));

    issue_start(vecs[0].chip, vecs[0].chan, vecs[0].rng);
    for (int n = 0; n <= 24 * D; n++) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    #3 RST_B = 1'b0;
    #1;
    chk("midreset_out", {BUSY, DONE, ERR, LVADCCLK, LVADCDATA, LVADCEN_B},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h7F});
    chk("midreset_data", 32'(DATA), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST_B = 1'b1;
    bad = 0;
    for (int i = 0; i < 60 * D; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY || DATA != 0 || LVADCEN_B !== 7'h7F) bad++;
    end
    chk("midreset_no_done", 32'(bad), 32'd0);
    issue_start(vecs[3].chip, vecs[3].chan, vecs[3].rng);
    run_frame("post_reset", vecs[3].val, vecs[3].exp_en, vecs[3].exp_ctrl, -1, 1'b0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvmon_adc_ctrl.md
# lvmon_adc_ctrl

Serial controller for the seven low-voltage monitoring ADCs (12-bit, 8-bit control byte, external-clock mode) on the DMB. It sits directly upstream of the front-panel connector multiplexer, which drives the ADC lines in LV-monitor mode. On a single START request it:
- selects one ADC;
- shifts out the control byte;
- clocks in the 12-bit conversion result;
- returns it to the VME register block with a one-cycle DONE strobe.

## Interface
Parameters:
- CLK_DIV, 4, half-period of LVADCCLK in CLK cycles. Legal range 2..255.

Ports (name, direction, width, meaning):
- CLK  in  1  system clock; the only clock.
- RST_B  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle request; accepted only in IDLE.
- CHIP  in  3  ADC select, 0..6; value 7 is illegal.
- CHAN  in  3  channel within the selected ADC.
- RNGBIP  in  2  range/bipolar bits of the control byte.
- BUSY  out  1  a frame is in progress.
- DONE  out  1  one-cycle strobe; DATA is valid from this cycle on.
- ERR  out  1  one-cycle strobe; the START had CHIP=7.
- DATA  out  12  last conversion result.
- LVADCCLK  out  1  ADC serial clock.
- LVADCDATA  out  1  ADC serial data in (control byte).
- LVADCEN_B  out  7  ADC chip selects, active-low; bit i selects ADC i.
- LVADCBACK  in  1  ADC serial data out, returned through the multiplexer.

## Operation
- States: IDLE, SEL, SHIFT, HOLD.
- Reset values: BUSY=0, DONE=0, ERR=0, DATA=0, LVADCCLK=0, LVADCDATA=0, LVADCEN_B=7'h7F; state IDLE.
- IDLE with START=1 and CHIP≤6:
  - latch CHIP, CHAN and RNGBIP;
  - go to SEL;
  - BUSY=1 and LVADCEN_B[CHIP]=0 from the next cycle.
- IDLE with START=1 and CHIP=7: pulse ERR for one cycle. There is no chip select, no DONE, DATA is unchanged, and the FSM stays in IDLE.
- START while BUSY=1 is ignored.
- Control byte = {1'b1, CHAN[2:0], RNGBIP[1:0], 2'b01}, shifted MSB first.
- SEL: lasts CLK_DIV cycles. LVADCCLK=0, LVADCDATA=0.
- SHIFT: 24 serial periods, p=1..24.
  - Each period is CLK_DIV cycles with LVADCCLK low, then CLK_DIV cycles with LVADCCLK high.
  - For p=1..8, LVADCDATA carries control bit 8-p for the whole period.
  - For p≥9, LVADCDATA=0.
- Readback:
  - LVADCBACK is sampled on the last CLK cycle of each high half, i.e. the cycle before LVADCCLK falls.
  - Read periods are r=p-8=1..16.
  - Samples at r=2..13 form the result, MSB first, in a 12-bit shift register.
  - Samples at r=1 and r=14..16 are discarded.
- HOLD: lasts CLK_DIV cycles. LVADCCLK=0 and the chip select stays low.
- End of HOLD:
  - state returns to IDLE;
  - LVADCEN_B=7'h7F;
  - BUSY=0 and DONE=1 in the same cycle;
  - DATA is loaded from the shift register in that cycle and then held until the next DONE or reset.
- Exactly one LVADCEN_B bit is low at any time, and only while BUSY=1.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). No DONE is issued. DATA returns to 0.

## Timing
- START sampled at edge k. From edge k: BUSY=1 and chip select low.
- First LVADCCLK rising edge at edge k+2·CLK_DIV.
- DONE at edge k+50·CLK_DIV, i.e. 200 cycles for CLK_DIV=4. DONE lasts exactly one cycle.
- LVADCCLK frequency = f_CLK/(2·CLK_DIV). Duty cycle is 50%, with no glitches.
- Chip select setup before the first rising edge: CLK_DIV cycles. Hold after the last falling edge: CLK_DIV cycles.
- LVADCDATA changes only on the cycle LVADCCLK falls, or at the SEL→SHIFT boundary. It is stable for CLK_DIV cycles before each rising edge.
- A START in the DONE cycle is accepted: the new frame begins with no idle gap, and LVADCEN_B reasserts on the next cycle.
- Counter widths must cover 2·CLK_DIV−1 cycles per period and 24 periods with no wrap-around inside a frame.

## Test plan
- Reset: hold RST_B=0 with START toggling -> all outputs at reset values and no LVADCCLK edges. Release -> outputs unchanged until START.
- CLK_DIV=4, CHIP=0, CHAN=5, RNGBIP=2'b10, ADC model returns 12'hA5C:
  - LVADCEN_B=7'b1111110 for the whole frame;
  - LVADCDATA shifts out 8'hD9;
  - exactly 24 LVADCCLK pulses;
  - DATA=12'hA5C with DONE 200 cycles after START.
- CHIP=6 with the model returning 12'hFFF, then 12'h000 -> LVADCEN_B=7'b0111111; DATA=12'hFFF, then 12'h000. Confirms the discarded r=1 and r=14..16 samples (model drives them inverted) do not leak into DATA.
- Back-to-back:
  - START pulsed at cycle 50 of a frame -> ignored, only one DONE;
  - START in the DONE cycle -> second frame starts and its DONE arrives 200 cycles later.
- CHIP=7 START -> ERR for one cycle; LVADCEN_B stays 7'h7F; no LVADCCLK edges; BUSY=0; DATA unchanged.
- RST_B pulsed low during serial period 12 -> outputs reset asynchronously and no DONE. The next START produces a normal frame with the correct DATA.
